// File: rtl/even_odd_pkg.sv
// Shared types for the even/odd tally stage: FSM states, sample classes and the
// flag-to-class decode.
package even_odd_pkg;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_ODD  = 2'b01,
        CLS_EVEN = 2'b10
    } cls_e;

    // Contradictory or missing flags (11 / 00) land in neither class.
    function automatic cls_e classify(input logic even, input logic odd);
        cls_e cls;
        case ({even, odd})
            2'b10:   cls = CLS_EVEN;
            2'b01:   cls = CLS_ODD;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/even_odd_run_tracker.sv
// Longest same-class run within one window. run_max is a look-ahead value that
// already includes the sample being stepped this cycle.
module even_odd_run_tracker
    import even_odd_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  cls_e             cls,
    output logic [CNT_W-1:0] run_max
);

    cls_e             r_prev;
    logic [CNT_W-1:0] r_run_cur;
    logic [CNT_W-1:0] r_run_max;
    logic [CNT_W-1:0] w_run_cur_nxt;
    logic [CNT_W-1:0] w_run_max_nxt;

    always_comb begin
        w_run_cur_nxt = r_run_cur;
        if (step) begin
            if (cls == CLS_NONE) begin
                w_run_cur_nxt = '0;
            end else if (cls == r_prev) begin
                w_run_cur_nxt = r_run_cur + CNT_W'(1);
            end else begin
                w_run_cur_nxt = CNT_W'(1);
            end
        end
        w_run_max_nxt = (w_run_cur_nxt > r_run_max) ? w_run_cur_nxt : r_run_max;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_prev    <= CLS_NONE;
            r_run_cur <= '0;
            r_run_max <= '0;
        end else if (step) begin
            r_prev    <= cls;
            r_run_cur <= w_run_cur_nxt;
            r_run_max <= w_run_max_nxt;
        end
    end

    assign run_max = w_run_max_nxt;

endmodule

// File: rtl/even_odd_tally.sv
// Windowed even/odd tally: counts classes over WIN_LEN accepted samples and holds
// one result record until the sink takes it. Flag checking: EVEN_ODD_CHECK_EN.
//
// state     | meaning
// ST_ACCUM  | accepting samples into the current window
// ST_REPORT | record valid, waiting for out_ready; input stalled
module even_odd_tally
    import even_odd_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int WIN_LEN = 8,
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_even,
    input  logic              in_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_even_cnt,
    output logic [CNT_W-1:0]  out_odd_cnt,
    output logic [CNT_W-1:0]  out_run_max,
    output logic [CNT_W-1:0]  out_err_cnt
);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIN_LEN - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_even_cnt;
    logic [CNT_W-1:0] r_odd_cnt;
    logic [CNT_W-1:0] r_rec_even;
    logic [CNT_W-1:0] r_rec_odd;
    logic [CNT_W-1:0] r_rec_run;
    logic [CNT_W-1:0] w_even_nxt;
    logic [CNT_W-1:0] w_odd_nxt;
    logic [CNT_W-1:0] w_run_max;
    logic             w_accept;
    logic             w_last;
    logic             w_handshake;
    cls_e             w_cls;
    logic             w_unused_a;

    assign w_cls       = classify(in_even, in_odd);
    assign w_accept    = in_valid & r_in_ready;
    assign w_last      = w_accept && (r_idx == IDX_LAST);
    assign w_handshake = r_out_valid & out_ready;
    assign w_even_nxt  = r_even_cnt + CNT_W'(w_cls == CLS_EVEN);
    assign w_odd_nxt   = r_odd_cnt + CNT_W'(w_cls == CLS_ODD);
    assign w_unused_a  = ^in_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM:  if (w_last)      w_state_nxt = ST_REPORT;
            ST_REPORT: if (w_handshake) w_state_nxt = ST_ACCUM;
            default:                    w_state_nxt = ST_ACCUM;
        endcase
    end

    // Handshake flags are registered so both stay low through reset and switch
    // together on the cycle after a window closes or a record is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_even_cnt  <= '0;
            r_odd_cnt   <= '0;
            r_rec_even  <= '0;
            r_rec_odd   <= '0;
            r_rec_run   <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_REPORT);
            if (w_handshake) begin
                r_idx      <= '0;
                r_even_cnt <= '0;
                r_odd_cnt  <= '0;
            end else if (w_accept) begin
                r_idx      <= w_last ? '0 : r_idx + CNT_W'(1);
                r_even_cnt <= w_even_nxt;
                r_odd_cnt  <= w_odd_nxt;
            end
            if (w_last) begin
                r_rec_even <= w_even_nxt;
                r_rec_odd  <= w_odd_nxt;
                r_rec_run  <= w_run_max;
            end
        end
    end

    even_odd_run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_handshake),
        .step    (w_accept),
        .cls     (w_cls),
        .run_max (w_run_max)
    );

`ifdef EVEN_ODD_CHECK_EN
    logic             w_flag_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_rec_err;

    // Counting still follows the flags; this only flags disagreement with bit 0.
    assign w_flag_err = ({in_even, in_odd} != {~in_a[0], in_a[0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
            r_rec_err <= '0;
        end else begin
            if (w_handshake) begin
                r_err_cnt <= '0;
            end else if (w_accept) begin
                r_err_cnt <= r_err_cnt + CNT_W'(w_flag_err);
            end
            if (w_last) begin
                r_rec_err <= r_err_cnt + CNT_W'(w_flag_err);
            end
        end
    end

    assign out_err_cnt = r_rec_err;
`else
    assign out_err_cnt = '0;
`endif

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_even_cnt = r_rec_even;
    assign out_odd_cnt  = r_rec_odd;
    assign out_run_max  = r_rec_run;

endmodule
